// File: rtl/series_accumulator_if.sv
// Term-stream and result bus between the upstream multiply stage and the series accumulator.
interface series_accumulator_if;
    logic        start;
    logic [31:0] term_in;
    logic        term_valid;
    logic        term_ovf;
    logic        term_ready;
    logic [31:0] sum_out;
    logic        sum_valid;
    logic        busy;
    logic        overflow;
    logic [3:0]  term_idx;

    modport master (
        output start, term_in, term_valid, term_ovf,
        input  term_ready, sum_out, sum_valid, busy, overflow, term_idx
    );

    modport slave (
        input  start, term_in, term_valid, term_ovf,
        output term_ready, sum_out, sum_valid, busy, overflow, term_idx
    );
endinterface

// File: rtl/series_accumulator.sv
// Accumulates NUM_TERMS signed Q16.16 terms (optionally alternating sign) with saturation.
module series_accumulator #(
    parameter int unsigned NUM_TERMS = 8,
    parameter int unsigned ALTERNATE = 1
) (
    input  logic               clk,
    input  logic               reset,
    series_accumulator_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned ACC_W  = DATA_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TERMS - 1);
    localparam logic [DATA_W-1:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 32'h8000_0000;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state, next_state;
    logic [DATA_W-1:0]  acc, acc_next;
    logic [IDX_W-1:0]   idx, idx_next;
    logic               ovf, ovf_next;
    logic               term_ready_q, busy_q, sum_valid_q;

    logic signed [ACC_W-1:0] term_ext_c, addend_c, sum_wide_c;
    logic                    negate_c, sat_c;
    logic [DATA_W-1:0]       sat_val_c;

    // 33-bit add/subtract so that negating 0x80000000 yields +2^31 before saturation.
    always_comb begin
        term_ext_c = $signed({bus.term_in[DATA_W-1], bus.term_in});
        negate_c   = (ALTERNATE != 0) && idx[0];
        addend_c   = negate_c ? -term_ext_c : term_ext_c;
        sum_wide_c = $signed({acc[DATA_W-1], acc}) + addend_c;
        sat_c      = sum_wide_c[ACC_W-1] != sum_wide_c[ACC_W-2];
        sat_val_c  = sum_wide_c[ACC_W-1] ? SAT_NEG : SAT_POS;
    end

    // Next-state and datapath update.
    always_comb begin
        next_state = state;
        acc_next   = acc;
        idx_next   = idx;
        ovf_next   = ovf;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_next   = '0;
                    idx_next   = '0;
                    ovf_next   = 1'b0;
                    next_state = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.term_valid) begin
                    acc_next = sat_c ? sat_val_c : sum_wide_c[DATA_W-1:0];
                    idx_next = idx + IDX_W'(1);
                    ovf_next = ovf | sat_c | bus.term_ovf;
                    if (idx == LAST_IDX) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            idx          <= '0;
            ovf          <= 1'b0;
            term_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            sum_valid_q  <= 1'b0;
        end else begin
            state        <= next_state;
            acc          <= acc_next;
            idx          <= idx_next;
            ovf          <= ovf_next;
            term_ready_q <= (next_state == ACCUM);
            busy_q       <= (next_state != IDLE);
            sum_valid_q  <= (next_state == DONE);
        end
    end

    assign bus.term_ready = term_ready_q;
    assign bus.busy       = busy_q;
    assign bus.sum_valid  = sum_valid_q;
    assign bus.sum_out    = acc;
    assign bus.term_idx   = idx;
    assign bus.overflow   = ovf;

endmodule

// File: tb/tb_series_accumulator.sv
// Scoreboard bench for series_accumulator: directed term sequences, monitor checks each sum_valid.
module tb_series_accumulator;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    series_accumulator_if ifa ();
    series_accumulator_if ifb ();

    series_accumulator #(.NUM_TERMS(4), .ALTERNATE(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    series_accumulator #(.NUM_TERMS(2), .ALTERNATE(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    typedef struct packed {
        logic [31:0] sum;
        logic        ovf;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] alt_terms [4];

    function automatic exp_t mk(input logic [31:0] s, input logic o);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic st, input logic tv, input logic [31:0] ti, input logic to);
        if (d == 0) begin
            ifa.start = st; ifa.term_valid = tv; ifa.term_in = ti; ifa.term_ovf = to;
        end else begin
            ifb.start = st; ifb.term_valid = tv; ifb.term_in = ti; ifb.term_ovf = to;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_eval(input int d);
        drive(d, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        drive(d, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic send(input int d, input logic [31:0] t, input logic o);
        drive(d, 1'b0, 1'b1, t, o);
        tick();
        drive(d, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    function automatic logic busy_of(input int d);
        return (d == 0) ? ifa.busy : ifb.busy;
    endfunction

    // Bounded wait for the evaluation to finish; an expired bound reports as a failure.
    task automatic wait_idle(input int d, input string name);
        int n = 0;
        while (busy_of(d) !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(busy_of(d)), 32'h0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sum_out"},    ifa.sum_out,            32'h0);
        check({tag, "_term_idx"},   32'(ifa.term_idx),      32'h0);
        check({tag, "_busy"},       32'(ifa.busy),          32'h0);
        check({tag, "_term_ready"}, 32'(ifa.term_ready),    32'h0);
        check({tag, "_overflow"},   32'(ifa.overflow),      32'h0);
        check({tag, "_sum_valid"},  32'(ifa.sum_valid),     32'h0);
    endtask

    // Monitor: pop an expected result on every sum_valid and check it lasts one cycle.
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (ifa.sum_valid === 1'b1) begin
            check("a_pulse_width", 32'(prev_a), 32'h0);
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_sum_valid: got pulse with sum 0x%08h expected no pulse", ifa.sum_out);
            end else begin
                e = qa.pop_front();
                check("a_sum_out", ifa.sum_out, e.sum);
                check("a_overflow", 32'(ifa.overflow), 32'(e.ovf));
            end
        end
        if (ifb.sum_valid === 1'b1) begin
            check("b_pulse_width", 32'(prev_b), 32'h0);
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_sum_valid: got pulse with sum 0x%08h expected no pulse", ifb.sum_out);
            end else begin
                e = qb.pop_front();
                check("b_sum_out", ifb.sum_out, e.sum);
                check("b_overflow", 32'(ifb.overflow), 32'(e.ovf));
            end
        end
        prev_a = (ifa.sum_valid === 1'b1);
        prev_b = (ifb.sum_valid === 1'b1);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1.0, 0.5, 0.3333, 0.25 in Q16.16
        alt_terms[0] = 32'h0001_0000;
        alt_terms[1] = 32'h0000_8000;
        alt_terms[2] = 32'h0000_5555;
        alt_terms[3] = 32'h0000_4000;

        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        check("rst_b_sum_out", ifb.sum_out, 32'h0);
        check("rst_b_busy", 32'(ifb.busy), 32'h0);
        reset = 1'b0;
        tick();

        // Alternating sum: 0x10000 - 0x8000 + 0x5555 - 0x4000 = 0x9555
        qa.push_back(mk(32'h0000_9555, 1'b0));
        start_eval(0);
        check("a_term_ready_accum", 32'(ifa.term_ready), 32'h1);
        check("a_busy_accum", 32'(ifa.busy), 32'h1);
        for (int k = 0; k < 4; k++) send(0, alt_terms[k], 1'b0);
        wait_idle(0, "a_idle_alt");

        // Same terms with three idle cycles between each; term_idx must step 0..3.
        qa.push_back(mk(32'h0000_9555, 1'b0));
        start_eval(0);
        for (int k = 0; k < 4; k++) begin
            check("a_term_idx_gap", 32'(ifa.term_idx), 32'(k));
            send(0, alt_terms[k], 1'b0);
            if (k < 3) repeat (3) tick();
        end
        wait_idle(0, "a_idle_gap");

        // Upstream overflow on the second term: 3 - 1 + 2 - 0.5 = 3.5
        qa.push_back(mk(32'h0003_8000, 1'b1));
        start_eval(0);
        send(0, 32'h0003_0000, 1'b0);
        send(0, 32'h0001_0000, 1'b1);
        send(0, 32'h0002_0000, 1'b0);
        send(0, 32'h0000_8000, 1'b0);
        wait_idle(0, "a_idle_uovf");

        // Negating the most negative term yields +2^31, which saturates.
        qa.push_back(mk(32'h7FFF_FFFF, 1'b1));
        start_eval(0);
        send(0, 32'h0000_0000, 1'b0);
        send(0, 32'h8000_0000, 1'b0);
        send(0, 32'h0000_0000, 1'b0);
        send(0, 32'h0000_0000, 1'b0);
        wait_idle(0, "a_idle_negmin");

        // Reset after two accepted terms aborts with no result.
        start_eval(0);
        send(0, alt_terms[0], 1'b0);
        send(0, alt_terms[1], 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_state("midrst");
        repeat (3) tick();
        qa.push_back(mk(32'h0000_9555, 1'b0));
        start_eval(0);
        for (int k = 0; k < 4; k++) send(0, alt_terms[k], 1'b0);
        wait_idle(0, "a_idle_after_rst");

        // Stray term_valid in IDLE must leave the held result alone.
        drive(0, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
        repeat (3) tick();
        drive(0, 1'b0, 1'b0, 32'h0, 1'b0);
        check("stray_idle_sum_out", ifa.sum_out, 32'h0000_9555);
        check("stray_idle_term_idx", 32'(ifa.term_idx), 32'h4);
        check("stray_idle_busy", 32'(ifa.busy), 32'h0);
        check("stray_idle_overflow", 32'(ifa.overflow), 32'h0);

        // Stray start during ACCUM must not restart the evaluation.
        qa.push_back(mk(32'h0000_9555, 1'b0));
        start_eval(0);
        send(0, alt_terms[0], 1'b0);
        start_eval(0);
        check("stray_start_term_idx", 32'(ifa.term_idx), 32'h1);
        check("stray_start_sum_out", ifa.sum_out, 32'h0001_0000);
        check("stray_start_busy", 32'(ifa.busy), 32'h1);
        for (int k = 1; k < 4; k++) send(0, alt_terms[k], 1'b0);
        wait_idle(0, "a_idle_stray");

        // All-add positive saturation: 0x7FFF0000 + 0x00020000 overflows.
        qb.push_back(mk(32'h7FFF_FFFF, 1'b1));
        start_eval(1);
        send(1, 32'h7FFF_0000, 1'b0);
        send(1, 32'h0002_0000, 1'b0);
        wait_idle(1, "b_idle_sat");
        repeat (3) tick();
        check("b_overflow_sticky", 32'(ifb.overflow), 32'h1);
        check("b_sum_out_hold", ifb.sum_out, 32'h7FFF_FFFF);
        start_eval(1);
        check("b_overflow_cleared", 32'(ifb.overflow), 32'h0);
        check("b_sum_out_cleared", ifb.sum_out, 32'h0);
        check("b_term_idx_cleared", 32'(ifb.term_idx), 32'h0);
        qb.push_back(mk(32'h0002_0000, 1'b0));
        send(1, 32'h0001_0000, 1'b0);
        send(1, 32'h0001_0000, 1'b0);
        wait_idle(1, "b_idle_plain");

        // Negative saturation: -2^31 + (-1.0) clamps to 0x80000000.
        qb.push_back(mk(32'h8000_0000, 1'b1));
        start_eval(1);
        send(1, 32'h8000_0000, 1'b0);
        send(1, 32'hFFFF_0000, 1'b0);
        wait_idle(1, "b_idle_negsat");

        repeat (3) tick();
        check("a_results_outstanding", 32'(qa.size()), 32'h0);
        check("b_results_outstanding", 32'(qb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
